// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the baud divisor,
// common to transmitter and receiver so both ends agree on bit timing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

    // Clock cycles per bit, rounded down.
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. Power-of-two depth, so the
// pointers wrap naturally; storage is not reset.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  wdata,
    input  logic        pop,
    output logic [7:0]  rdata,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_en, pop_en;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    // A push while full is dropped here; a same-cycle pop does not make room.
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: byte FIFO in front of a start/data/stop serializer.
// The line output is registered and changes on the same edge as the FSM state.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          UART_TX,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV   = baud_div(CLK_FREQ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             pop, bit_end;
    logic [7:0]       fifo_rdata;
    logic             fifo_full, fifo_empty;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_ready = !fifo_full;
    assign UART_TX  = tx_q;
    assign busy     = (state_q != IDLE) || (fifo_count != '0);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        bit_end = (baud_q == LAST);
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    bit_d   = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Next bit is shift_q[1], i.e. shift[0] after this shift.
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized + directed bench for uart_tx with a frame-level line model.
module tb_uart_tx;

    localparam int DEPTH = 4;
    localparam int DIV   = 10;          // 1000 Hz / 100 baud
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, UART_TX, busy;
    logic [2:0] fifo_count;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    uart_tx #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .UART_TX    (UART_TX),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Model: queue of accepted bytes plus the frame currently on the line,
    // tracked as a cycle offset into a 10-bit 8N1 frame.
    logic [7:0] mq[$];
    bit         m_active = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_byte = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_pos = 0;
        end else begin
            bit acc;
            acc = tx_valid && (mq.size() < DEPTH);
            if (m_active) begin
                m_pos++;
                if (m_pos == FRAME) m_active = 1'b0;
            end else if (mq.size() > 0) begin
                m_byte = mq.pop_front();
                m_active = 1'b1;
                m_pos = 0;
            end
            if (acc) mq.push_back(tx_data);
        end
    end

    function automatic logic exp_line();
        int b;
        if (!m_active) return 1'b1;
        b = m_pos / DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("line",  {31'd0, UART_TX}, {31'd0, exp_line()});
            check("count", {29'd0, fifo_count}, mq.size());
            check("ready", {31'd0, tx_ready}, {31'd0, mq.size() < DEPTH});
            check("busy",  {31'd0, busy}, {31'd0, m_active || mq.size() != 0});
        end
    end

    task automatic push1(input logic [7:0] b);
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((busy !== 1'b0 || m_active || mq.size() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [9:0] pat55;
        logic [7:0] hold_b[6];
        logic [7:0] burst[4];
        int idx, guard, n, maxc;
        bit r, seen_full, found;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_line",  {31'd0, UART_TX}, 32'd1);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);

        // Single 0x55 frame: low one edge after accept, alternating bits.
        pat55 = 10'b1010101010;
        push1(8'h55);
        check("p55_count_after_push", {29'd0, fifo_count}, 32'd1);
        @(negedge clk);
        check("p55_start_low", {31'd0, UART_TX}, 32'd0);
        check("p55_popped", {29'd0, fifo_count}, 32'd0);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("p55_bit%0d", i), {31'd0, UART_TX}, {31'd0, pat55[i]});
            if (i < 9) repeat (DIV) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("p55_busy_fall", {31'd0, busy}, 32'd0);
        check("p55_idle_high", {31'd0, UART_TX}, 32'd1);

        // Back-to-back burst of four bytes.
        burst[0] = 8'hA3; burst[1] = 8'h00; burst[2] = 8'hFF; burst[3] = 8'h3C;
        maxc = 0;
        for (int i = 0; i < 4; i++) begin
            tx_data = burst[i];
            tx_valid = 1'b1;
            @(negedge clk);
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        end
        tx_valid = 1'b0;
        check("burst_max_count", maxc, 32'd3);
        wait_idle(6 * FRAME);

        // tx_valid held high through a full FIFO.
        for (int i = 0; i < 6; i++) hold_b[i] = 8'h10 + 8'(i * 17);
        idx = 0; guard = 0; seen_full = 1'b0;
        tx_data = hold_b[0];
        tx_valid = 1'b1;
        while (idx < 6 && guard < 3000) begin
            r = tx_ready;
            @(negedge clk);
            guard++;
            if (fifo_count == 3'd4 && !tx_ready) seen_full = 1'b1;
            if (r) begin
                idx++;
                if (idx < 6) tx_data = hold_b[idx];
            end
        end
        tx_valid = 1'b0;
        check("hold_full_seen", {31'd0, seen_full}, 32'd1);
        check("hold_all_accepted", idx, 32'd6);
        wait_idle(8 * FRAME);

        // Reset during data bit 3 of 0x0F with a second byte queued.
        push1(8'h0F);
        push1(8'h11);
        repeat (45) @(negedge clk);
        check("rst_mid_bit3", {31'd0, UART_TX}, 32'd1);
        check("rst_mid_queued", {29'd0, fifo_count}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_line", {31'd0, UART_TX}, 32'd1);
        check("rst_mid_count", {29'd0, fifo_count}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        repeat (150) @(negedge clk);
        check("rst_mid_quiet", {31'd0, busy}, 32'd0);

        // Push on the same edge the FSM pops with two bytes queued.
        push1(8'hA1);
        push1(8'hB2);
        push1(8'hC3);
        n = 0; found = 1'b0;
        while (n < 300 && !found) begin
            if (!m_active && mq.size() == 2) found = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check("pop_edge_found", {31'd0, found}, 32'd1);
        push1(8'hD4);
        check("push_pop_count", {29'd0, fifo_count}, 32'd2);
        wait_idle(6 * FRAME);

        // 0x80 at DIV=10: 80 low cycles (start + 7 zeros), then 20 high.
        push1(8'h80);
        @(negedge clk);
        n = 0;
        while (UART_TX === 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("div10_low_run", n, 32'd80);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("div10_high_run", n, 32'd20);

        // Random traffic with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 1499) == 0) begin
                tx_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                tx_valid = (c % 1000 < 300) ? ($urandom_range(0, 1) == 0)
                                            : ($urandom_range(0, 60) == 0);
                tx_data = 8'($urandom);
                @(negedge clk);
            end
        end
        tx_valid = 1'b0;
        wait_idle(6 * FRAME);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4, number of byte entries in the transmit FIFO (power of two, 2..16).
REQ-004 clk  input  1  system clock; the block has one clock, and all state updates on the rising edge of clk.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 tx_data  input  8  byte to transmit, sampled when tx_valid and tx_ready are both high.
REQ-007 tx_valid  input  1  producer has a byte on tx_data.
REQ-008 tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 UART_TX  output  1  serial line, idle high, 8N1, LSB first.
REQ-010 busy  output  1  a frame is on the line, or the FIFO is non-empty.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued and not yet popped.

Function
REQ-012 DIV SHALL equal CLK_FREQ/BAUD, rounded down (5208 at the defaults); every bit SHALL last exactly DIV clk cycles.
REQ-013 Transfer: the FIFO SHALL accept a byte on each rising edge where tx_valid and tx_ready are both high; a byte SHALL NOT be accepted otherwise.
REQ-014 tx_ready SHALL be combinational and SHALL equal (fifo_count < FIFO_DEPTH).
REQ-015 When full, a pop in the current cycle SHALL NOT raise tx_ready in that same cycle.
REQ-016 Simultaneous push and pop with 0 < fifo_count < FIFO_DEPTH SHALL leave fifo_count unchanged and preserve byte order.
REQ-017 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-018 In IDLE, UART_TX SHALL be 1; if the FIFO is non-empty, the FSM SHALL pop the head byte into an 8-bit shift register, clear the bit counter, and enter START.
REQ-019 In START, UART_TX SHALL be 0 for DIV cycles, after which the FSM SHALL enter DATA.
REQ-020 In DATA, UART_TX SHALL be shift[0] for DIV cycles per bit; the shift register SHALL shift right and the 3-bit index SHALL increment; after bit 7 the FSM SHALL enter STOP.
REQ-021 In STOP, UART_TX SHALL be 1 for DIV cycles, after which the FSM SHALL return to IDLE.
REQ-022 The IDLE cycle in REQ-021 SHALL pop the next byte if one is present, giving a gap of exactly one clk between back-to-back frames.
REQ-023 Latency: a byte pushed into an empty FIFO while in IDLE SHALL drive UART_TX low starting at the rising edge immediately after the accepting edge.
REQ-024 The baud counter SHALL count 0..DIV-1, wrap to 0 on each bit boundary, and be held at 0 in IDLE.
REQ-025 UART_TX SHALL be driven from a flip-flop (glitch-free).
REQ-026 busy SHALL equal (state != IDLE) || (fifo_count != 0).
REQ-027 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 Overflow SHALL be impossible given REQ-013; a tx_valid held high while full SHALL be ignored without data loss of queued bytes.

Reset
REQ-029 While rst is high, the block SHALL drive UART_TX=1, state=IDLE, baud counter=0, bit index=0, fifo_count=0, FIFO pointers=0, tx_ready=1 and busy=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame: UART_TX returns to 1 on the next edge and all queued bytes are discarded.
REQ-031 FIFO storage contents need not be reset.

Structure
REQ-032 The shared package uart_pkg SHALL hold the state encoding (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11) and the baud-divisor function.
REQ-033 uart_pkg SHALL be reused by the receiver so that both ends agree on the divisor.
REQ-034 The FIFO SHALL be a separate sub-module, uart_tx_fifo (push/pop/count/full/empty); the FSM and serializer SHALL live in uart_tx.

Verification
REQ-035 Push 0x55 once at the default parameters -> UART_TX low one edge later, bit sequence 0,1,0,1,0,1,0,1,0,1, each 5208 cycles, then idle high; busy falls after STOP.
REQ-036 Push 0xA3, 0x00, 0xFF, 0x3C back-to-back -> fifo_count reaches 3 (first byte popped), four contiguous frames with one-cycle gaps, received bytes match order.
REQ-037 Hold tx_valid high with 6 distinct bytes while the line is busy -> tx_ready low at fifo_count=4, no byte lost or duplicated, all 6 transmitted in order.
REQ-038 Assert rst for 1 cycle during DATA bit 3 of 0x0F -> UART_TX=1 next edge, fifo_count=0, no further frame until a new push.
REQ-039 Push on the same edge the FSM pops (fifo_count=2) -> fifo_count stays 2 and the transmitted order is preserved.
REQ-040 CLK_FREQ=1000, BAUD=100 (DIV=10) with byte 0x80 -> each bit lasts 10 cycles and total frame length is 100 cycles.
